// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - shared defaults and FSM state type for mem_access_ctrl
//
// Purpose: holds the default geometry of the controlled memory and the
// controller state encoding so the top and any future helpers agree on both.
package mem_access_ctrl_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int ADDR_W_DEF    = 2;
  localparam int WORD_NUMB_DEF = 4;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_CAPTURE,
    ST_RESP
  } state_t;

endpackage

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - single-port memory access controller with clear-on-reset
//
// Purpose: clears the memory after reset, then serves one read or write request
// at a time over a valid/ready request channel and a valid/ready response channel.
// Every output is a flop; each edge loads the outputs belonging to the state the
// FSM is entering, so strobes line up with the state they describe.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   req_valid/req_ready          request handshake (ready only in IDLE)
//   req_write/req_addr/req_wdata request fields, captured on acceptance
//   rsp_valid/rsp_ready          read response handshake
//   rsp_rdata                    read data (0 for addresses outside the memory)
//   mem_addr/mem_write_en/mem_read_en/mem_write_in/mem_read_out  memory port
//   init_done                    memory clear sequence complete
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int WORD_NUMB = WORD_NUMB_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write_en,
  output logic              mem_read_en,
  output logic [DATA_W-1:0] mem_write_in,
  input  logic [DATA_W-1:0] mem_read_out,
  output logic              init_done
);

  // One extra bit so the counter can reach WORD_NUMB, which marks the end of INIT.
  localparam logic [ADDR_W:0] WORDS = (ADDR_W+1)'(WORD_NUMB);

  state_t          state;
  logic [ADDR_W:0] init_cnt;
  logic            req_hit;       // accepted address lies inside the memory
  logic            req_in_range;

  assign req_in_range = ({1'b0, req_addr} < WORDS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_INIT;
      init_cnt     <= '0;
      req_hit      <= 1'b0;
      req_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      mem_addr     <= '0;
      mem_write_en <= 1'b0;
      mem_read_en  <= 1'b0;
      mem_write_in <= '0;
      init_done    <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (init_cnt == WORDS) begin
            mem_write_en <= 1'b0;
            init_done    <= 1'b1;
            req_ready    <= 1'b1;
            state        <= ST_IDLE;
          end else begin
            mem_write_en <= 1'b1;
            mem_addr     <= init_cnt[ADDR_W-1:0];
            mem_write_in <= '0;
            init_cnt     <= init_cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          // req_ready is 1 here, so req_valid alone means acceptance.
          if (req_valid) begin
            req_ready <= 1'b0;
            mem_addr  <= req_addr;
            req_hit   <= req_in_range;
            if (req_write) begin
              mem_write_en <= req_in_range;  // out-of-range writes are dropped
              mem_write_in <= req_wdata;
              state        <= ST_WRITE;
            end else begin
              mem_read_en <= req_in_range;   // out-of-range reads skip the memory
              state       <= ST_READ;
            end
          end
        end
        ST_WRITE: begin
          mem_write_en <= 1'b0;
          req_ready    <= 1'b1;
          state        <= ST_IDLE;
        end
        ST_READ: begin
          mem_read_en <= 1'b0;
          state       <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          rsp_rdata <= req_hit ? mem_read_out : '0;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance: 4 words, all addresses valid.
  logic       req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
  logic [1:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       req_ready, rsp_valid, mem_write_en, mem_read_en, init_done;
  logic [7:0] rsp_rdata, mem_write_in;
  logic [1:0] mem_addr;
  logic [7:0] mem_read_out;
  logic [7:0] mem0 [4];

  mem_access_ctrl #(.DATA_W(8), .ADDR_W(2), .WORD_NUMB(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
    .mem_write_in(mem_write_in), .mem_read_out(mem_read_out), .init_done(init_done)
  );

  always @(posedge clk) begin
    if (mem_write_en) mem0[mem_addr] <= mem_write_in;
    if (mem_read_en)  mem_read_out   <= mem0[mem_addr];
  end

  // Second instance: 3 words, address 3 is out of range.
  logic       req_valid_b = 1'b0, req_write_b = 1'b0, rsp_ready_b = 1'b0;
  logic [1:0] req_addr_b = '0;
  logic [7:0] req_wdata_b = '0;
  logic       req_ready_b, rsp_valid_b, mem_write_en_b, mem_read_en_b, init_done_b;
  logic [7:0] rsp_rdata_b, mem_write_in_b;
  logic [1:0] mem_addr_b;
  logic [7:0] mem_read_out_b;
  logic [7:0] mem1 [4];

  mem_access_ctrl #(.DATA_W(8), .ADDR_W(2), .WORD_NUMB(3)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_write(req_write_b),
    .req_addr(req_addr_b), .req_wdata(req_wdata_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_rdata(rsp_rdata_b),
    .mem_addr(mem_addr_b), .mem_write_en(mem_write_en_b), .mem_read_en(mem_read_en_b),
    .mem_write_in(mem_write_in_b), .mem_read_out(mem_read_out_b), .init_done(init_done_b)
  );

  always @(posedge clk) begin
    if (mem_write_en_b) mem1[mem_addr_b] <= mem_write_in_b;
    if (mem_read_en_b)  mem_read_out_b   <= mem1[mem_addr_b];
  end

  int checks = 0, errors = 0;
  int both_cnt = 0, wr_cnt = 0, rsp_cnt = 0, wr_b_cnt = 0, rd_b_cnt = 0;
  logic [7:0] ref_mem [4];
  logic [7:0] exp_q [$];

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_write_en && mem_read_en) both_cnt++;
      if (init_done && mem_write_en) wr_cnt++;
      if (init_done_b && mem_write_en_b) wr_b_cnt++;
      if (init_done_b && mem_read_en_b) rd_b_cnt++;
    end
  end

  task automatic issue(input logic w, input logic [1:0] a, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (req_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL issue_timeout: req_ready=%b required 1", req_ready);
    end
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    // Scramble the request lines after acceptance; they must be ignored.
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = 2'($urandom); req_wdata = 8'($urandom);
    if (w) ref_mem[a] = d;
    else   exp_q.push_back(ref_mem[a]);
  endtask

  task automatic collect(input int hold);
    int n = 0;
    logic [7:0] d0, e;
    @(negedge clk);
    while (rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL rsp_timeout: rsp_valid=%b required 1", rsp_valid);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    d0 = rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== d0 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL rsp_hold: valid=%b rdata=%h ready=%b required 1/%h/0", rsp_valid, rsp_rdata, req_ready, d0);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    rsp_cnt++;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL rsp_extra: rdata=%h with no read outstanding", d0);
    end else begin
      e = exp_q.pop_front();
      if (d0 !== e) begin
        errors++;
        $display("FAIL rsp_data: rdata=%h required %h", d0, e);
      end
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rsp_release: valid=%b ready=%b required 0/1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, mem_write_en, mem_read_en, init_done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready/valid/we/re/done=%b required 00000",
               {req_ready, rsp_valid, mem_write_en, mem_read_en, init_done});
    end
    checks++;
    if (rsp_rdata !== 8'h00 || mem_addr !== 2'd0 || mem_write_in !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: rdata=%h addr=%0d wdata=%h required 0", rsp_rdata, mem_addr, mem_write_in);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (mem_write_en !== 1'b1 || mem_addr !== 2'(i) || mem_write_in !== 8'h00 || init_done !== 1'b0) begin
        errors++;
        $display("FAIL init_word%0d: we=%b addr=%0d data=%h done=%b required 1/%0d/00/0",
                 i, mem_write_en, mem_addr, mem_write_in, init_done, i);
      end
    end
    @(negedge clk);
    checks++;
    if (init_done !== 1'b1 || req_ready !== 1'b1 || mem_write_en !== 1'b0) begin
      errors++;
      $display("FAIL init_done: done=%b ready=%b we=%b required 1/1/0", init_done, req_ready, mem_write_en);
    end
    foreach (ref_mem[i]) ref_mem[i] = 8'h00;
  endtask

  task automatic test_write_read();
    int w0;
    logic [7:0] d, e;
    w0 = wr_cnt;
    issue(1'b1, 2'd2, 8'hA5);
    @(negedge clk);
    checks++;
    if (mem_write_en !== 1'b1 || mem_addr !== 2'd2 || mem_write_in !== 8'hA5) begin
      errors++;
      $display("FAIL wr_strobe: we=%b addr=%0d data=%h required 1/2/a5", mem_write_en, mem_addr, mem_write_in);
    end
    issue(1'b0, 2'd2, 8'h00);
    checks++;
    if (wr_cnt - w0 !== 1) begin
      errors++;
      $display("FAIL wr_count: strobes=%0d required 1", wr_cnt - w0);
    end
    @(negedge clk);
    checks++;
    if (mem_read_en !== 1'b1 || mem_write_en !== 1'b0 || mem_addr !== 2'd2) begin
      errors++;
      $display("FAIL rd_strobe: re=%b we=%b addr=%0d required 1/0/2", mem_read_en, mem_write_en, mem_addr);
    end
    @(negedge clk);
    checks++;
    if (mem_read_en !== 1'b0 || rsp_valid !== 1'b0 || mem_addr !== 2'd2) begin
      errors++;
      $display("FAIL capture: re=%b valid=%b addr=%0d required 0/0/2", mem_read_en, rsp_valid, mem_addr);
    end
    @(negedge clk);
    d = rsp_rdata;
    checks++;
    if (rsp_valid !== 1'b1 || d !== 8'hA5) begin
      errors++;
      $display("FAIL rd_latency: valid=%b rdata=%h required 1/a5", rsp_valid, d);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL rd_scoreboard: rdata=%h required %h", d, e);
    end
  endtask

  task automatic test_hold();
    issue(1'b1, 2'd1, 8'h3C);
    issue(1'b0, 2'd1, 8'h00);
    collect(5);
  endtask

  task automatic test_random();
    int nw = 0, nr = 0, w0, r0, b0;
    logic w;
    w0 = wr_cnt; r0 = rsp_cnt; b0 = both_cnt;
    for (int i = 0; i < 250; i++) begin
      w = 1'($urandom);
      issue(w, 2'($urandom), 8'($urandom));
      if (w) nw++;
      else begin nr++; collect(int'($urandom_range(0, 3))); end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (both_cnt - b0 !== 0) begin
      errors++;
      $display("FAIL strobe_overlap: cycles=%0d required 0", both_cnt - b0);
    end
    checks++;
    if (wr_cnt - w0 !== nw) begin
      errors++;
      $display("FAIL rand_writes: strobes=%0d required %0d", wr_cnt - w0, nw);
    end
    checks++;
    if (rsp_cnt - r0 !== nr || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rand_reads: responses=%0d left=%0d required %0d/0", rsp_cnt - r0, exp_q.size(), nr);
    end
  endtask

  task automatic test_reset_resp();
    int n = 0;
    issue(1'b1, 2'd3, 8'hC3);
    issue(1'b0, 2'd3, 8'h00);
    @(negedge clk);
    while (rsp_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_rsp: valid=%b required 1", rsp_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || init_done !== 1'b0 || req_ready !== 1'b0 || rsp_rdata !== 8'h00) begin
      errors++;
      $display("FAIL rst_async: valid=%b done=%b ready=%b rdata=%h required 0/0/0/00",
               rsp_valid, init_done, req_ready, rsp_rdata);
    end
    exp_q.delete();
    foreach (ref_mem[i]) ref_mem[i] = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (init_done !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (init_done !== 1'b1 || n != 5) begin
      errors++;
      $display("FAIL reinit: done=%b after %0d cycles required 1 after 5", init_done, n);
    end
    for (int a = 0; a < 4; a++) begin
      issue(1'b0, 2'(a), 8'h00);
      collect(0);
    end
  endtask

  task automatic issue_b(input logic w, input logic [1:0] a, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    while (req_ready_b !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (req_ready_b !== 1'b1) begin
      checks++; errors++;
      $display("FAIL issue_b_timeout: req_ready=%b required 1", req_ready_b);
    end
    req_valid_b = 1'b1; req_write_b = w; req_addr_b = a; req_wdata_b = d;
    @(posedge clk); #1;
    req_valid_b = 1'b0;
  endtask

  task automatic test_out_of_range();
    int n = 0, wb, rb;
    logic [7:0] d;
    issue_b(1'b1, 2'd1, 8'h77);
    issue_b(1'b0, 2'd1, 8'h00);
    @(negedge clk);
    while (rsp_valid_b !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    d = rsp_rdata_b;
    checks++;
    if (rsp_valid_b !== 1'b1 || d !== 8'h77) begin
      errors++;
      $display("FAIL b_inrange: valid=%b rdata=%h required 1/77", rsp_valid_b, d);
    end
    rsp_ready_b = 1'b1;
    @(posedge clk); #1;
    rsp_ready_b = 1'b0;
    wb = wr_b_cnt; rb = rd_b_cnt;
    issue_b(1'b1, 2'd3, 8'h5A);
    @(negedge clk);
    checks++;
    if (mem_write_en_b !== 1'b0 || req_ready_b !== 1'b0) begin
      errors++;
      $display("FAIL b_drop_write: we=%b ready=%b required 0/0", mem_write_en_b, req_ready_b);
    end
    issue_b(1'b0, 2'd3, 8'h00);
    repeat (3) @(negedge clk);
    d = rsp_rdata_b;
    checks++;
    if (rsp_valid_b !== 1'b1 || d !== 8'h00) begin
      errors++;
      $display("FAIL b_oor_read: valid=%b rdata=%h required 1/00", rsp_valid_b, d);
    end
    rsp_ready_b = 1'b1;
    @(posedge clk); #1;
    rsp_ready_b = 1'b0;
    checks++;
    if (wr_b_cnt != wb || rd_b_cnt != rb) begin
      errors++;
      $display("FAIL b_strobes: writes=%0d reads=%0d required 0/0", wr_b_cnt - wb, rd_b_cnt - rb);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_hold();
    test_random();
    test_reset_resp();
    test_out_of_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
